ack_rx_parser: RTL and testbench

AXI-Stream receiver for inbound ACK frames arriving from sysnet. It is the receive-side counterpart of ack_queue, which emits ACK frames. The block parses the header beat of each frame and extracts the acknowledged sequence number per application (APP0/APP1). It filters stale or duplicate ACKs using wrap-safe serial-number comparison, then publishes per-app ack pulses plus a held "highest acked" value. Malformed and non-ACK frames are drained and counted.

---
 rtl/ack_pkg.sv | 35 +++
 rtl/ack_rx_parser_sat_counter.sv | 36 +++
 rtl/ack_rx_parser.sv | 185 ++++++++++++++++++
 tb/tb_ack_rx_parser.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ack_pkg.sv
// -----------------------------------------------------------------------------
// ack_pkg
// Shared definitions for the ACK frame producer (ack_queue) and consumer
// (ack_rx_parser): message type, header field offsets, parser FSM states and
// the wrap-safe sequence comparison.
// -----------------------------------------------------------------------------
package ack_pkg;

   // Message-type byte identifying an ACK frame
   localparam logic [7:0] ACK_TYPE  = 8'h06;

   // Header beat field offsets (bit positions inside tdata)
   localparam int         TYPE_LSB  = 0;
   localparam int         APP_LSB   = 8;
   localparam int         SEQ_LSB   = 16;

   // Bytes that must be present for a header to be usable
   localparam int         HDR_BYTES = 6;

   // Receive FSM: S_HDR expects a header beat, S_DRAIN discards the frame tail
   typedef enum logic [0:0] {
      S_HDR   = 1'b0,
      S_DRAIN = 1'b1
   } rx_state_e;

   // True when a is strictly newer than b in 32-bit serial-number arithmetic:
   // the difference a-b, read as a signed value, must be positive. A difference
   // of exactly 2^31 is negative and therefore not newer.
   function automatic logic seq_newer(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] diff_s;
      diff_s = a - b;
      return (diff_s[31] == 1'b0) && (diff_s != 32'h0000_0000);
   endfunction

endpackage

// File: rtl/ack_rx_parser_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that stops at all-ones instead of wrapping.
//   clk    : system clock
//   resetn : asynchronous active-low reset, clears the count
//   inc    : count one event this cycle
//   count  : registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_r;
   logic             at_max_s;

   assign at_max_s = (count_r == {CNT_W{1'b1}});

   // Count register, held once it reaches all-ones
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_r <= {CNT_W{1'b0}};
      end else if (inc && !at_max_s) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/ack_rx_parser.sv
// -----------------------------------------------------------------------------
// ack_rx_parser
// AXI-Stream receiver for inbound ACK frames. The first beat of every frame is
// parsed as a header {seq[47:16], app_id[15:8], type[7:0]}; remaining beats are
// drained. Newer ACKs for APP0/APP1 update a held sequence value and raise a
// one-cycle pulse; everything else is counted as a drop. Never backpressures.
//
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   rx_tdata/tkeep/tuser  : AXIS beat (tuser ignored)
//   rx_tvalid/tlast       : AXIS valid, end of frame
//   rx_tready             : AXIS ready, 0 in reset and 1 afterwards
//   ack0_seq/ack0_valid   : highest accepted APP0 sequence, advance pulse
//   ack1_seq/ack1_valid   : highest accepted APP1 sequence, advance pulse
//   frames_ok/frames_drop : saturating accepted / dropped frame counts
// -----------------------------------------------------------------------------
module ack_rx_parser #(
   parameter int         DATA_W   = 512,
   parameter int         USER_W   = 64,
   parameter logic [7:0] ACK_TYPE = ack_pkg::ACK_TYPE,
   parameter int         CNT_W    = 16
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [DATA_W-1:0]   rx_tdata,
   input  logic [DATA_W/8-1:0] rx_tkeep,
   input  logic [USER_W-1:0]   rx_tuser,
   input  logic                rx_tvalid,
   input  logic                rx_tlast,
   output logic                rx_tready,
   output logic [31:0]         ack0_seq,
   output logic                ack0_valid,
   output logic [31:0]         ack1_seq,
   output logic                ack1_valid,
   output logic [CNT_W-1:0]    frames_ok,
   output logic [CNT_W-1:0]    frames_drop
);

   import ack_pkg::*;

   rx_state_e   state_r;
   rx_state_e   state_next_s;

   logic        tready_r;
   logic [31:0] ack0_seq_r;
   logic [31:0] ack1_seq_r;
   logic        ack0_valid_r;
   logic        ack1_valid_r;
   logic [1:0]  seen_r;

   logic        beat_fire_s;
   logic        hdr_fire_s;
   logic [7:0]  hdr_type_s;
   logic [7:0]  hdr_app_s;
   logic [31:0] hdr_seq_s;
   logic        hdr_ok_s;
   logic        accept0_s;
   logic        accept1_s;
   logic        reject_s;
   logic        ok_inc_s;

   // Payload above the header, upper byte enables and sideband are not used
   logic        unused_s;
   assign unused_s = ^{rx_tuser, rx_tdata[DATA_W-1:HDR_BYTES*8], rx_tkeep[DATA_W/8-1:HDR_BYTES]};

   assign beat_fire_s = rx_tvalid && tready_r;
   assign hdr_fire_s  = beat_fire_s && (state_r == S_HDR);
   assign hdr_type_s  = rx_tdata[TYPE_LSB +: 8];
   assign hdr_app_s   = rx_tdata[APP_LSB +: 8];
   assign hdr_seq_s   = rx_tdata[SEQ_LSB +: 32];

   // Header classification: type, full header bytes and per-app freshness
   always_comb begin
      hdr_ok_s  = 1'b0;
      accept0_s = 1'b0;
      accept1_s = 1'b0;
      reject_s  = 1'b0;
      if (hdr_fire_s) begin
         hdr_ok_s  = (hdr_type_s == ACK_TYPE) &&
                     (rx_tkeep[HDR_BYTES-1:0] == {HDR_BYTES{1'b1}});
         // The first ACK after reset is taken unconditionally: there is no
         // previous value to compare against.
         accept0_s = hdr_ok_s && (hdr_app_s == 8'd0) &&
                     (!seen_r[0] || seq_newer(hdr_seq_s, ack0_seq_r));
         accept1_s = hdr_ok_s && (hdr_app_s == 8'd1) &&
                     (!seen_r[1] || seq_newer(hdr_seq_s, ack1_seq_r));
         reject_s  = !(accept0_s || accept1_s);
      end else begin
         hdr_ok_s  = 1'b0;
      end
   end

   assign ok_inc_s = accept0_s || accept1_s;

   // Next-state: a header without tlast opens a frame that must be drained
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_HDR: begin
            if (beat_fire_s && !rx_tlast) begin
               state_next_s = S_DRAIN;
            end else begin
               state_next_s = S_HDR;
            end
         end
         S_DRAIN: begin
            if (beat_fire_s && rx_tlast) begin
               state_next_s = S_HDR;
            end else begin
               state_next_s = S_DRAIN;
            end
         end
         default: begin
            state_next_s = S_HDR;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= S_HDR;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Ready is held low only while in reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tready_r <= 1'b0;
      end else begin
         tready_r <= 1'b1;
      end
   end

   // Per-app held sequence, advance pulse and seen flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ack0_seq_r   <= 32'h0000_0000;
         ack1_seq_r   <= 32'h0000_0000;
         ack0_valid_r <= 1'b0;
         ack1_valid_r <= 1'b0;
         seen_r       <= 2'b00;
      end else begin
         ack0_valid_r <= accept0_s;
         ack1_valid_r <= accept1_s;
         if (accept0_s) begin
            ack0_seq_r <= hdr_seq_s;
            seen_r[0]  <= 1'b1;
         end else begin
            ack0_seq_r <= ack0_seq_r;
            seen_r[0]  <= seen_r[0];
         end
         if (accept1_s) begin
            ack1_seq_r <= hdr_seq_s;
            seen_r[1]  <= 1'b1;
         end else begin
            ack1_seq_r <= ack1_seq_r;
            seen_r[1]  <= seen_r[1];
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (ok_inc_s),
      .count  (frames_ok)
   );

   sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (reject_s),
      .count  (frames_drop)
   );

   assign rx_tready  = tready_r;
   assign ack0_seq   = ack0_seq_r;
   assign ack1_seq   = ack1_seq_r;
   assign ack0_valid = ack0_valid_r;
   assign ack1_valid = ack1_valid_r;

endmodule

// File: tb/tb_ack_rx_parser.sv
// -----------------------------------------------------------------------------
// tb_ack_rx_parser
// Table of single-beat ACK frames with constant expected outputs, hand-written
// multi-beat / gap / mid-frame reset sequences, then a random stream checked
// against a frame-level reference model. Counters are built narrow so that
// saturation is reached during the random phase.
// -----------------------------------------------------------------------------
module tb_ack_rx_parser;

   localparam int DATA_W  = 512;
   localparam int USER_W  = 64;
   localparam int CNT_W   = 8;
   localparam int KEEP_W  = DATA_W/8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                clk = 1'b0;
   logic                resetn;
   logic [DATA_W-1:0]   rx_tdata;
   logic [KEEP_W-1:0]   rx_tkeep;
   logic [USER_W-1:0]   rx_tuser;
   logic                rx_tvalid;
   logic                rx_tlast;
   logic                rx_tready;
   logic [31:0]         ack0_seq;
   logic                ack0_valid;
   logic [31:0]         ack1_seq;
   logic                ack1_valid;
   logic [CNT_W-1:0]    frames_ok;
   logic [CNT_W-1:0]    frames_drop;

   always #5 clk = ~clk;

   ack_rx_parser #(
      .DATA_W   (DATA_W),
      .USER_W   (USER_W),
      .ACK_TYPE (8'h06),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .rx_tdata    (rx_tdata),
      .rx_tkeep    (rx_tkeep),
      .rx_tuser    (rx_tuser),
      .rx_tvalid   (rx_tvalid),
      .rx_tlast    (rx_tlast),
      .rx_tready   (rx_tready),
      .ack0_seq    (ack0_seq),
      .ack0_valid  (ack0_valid),
      .ack1_seq    (ack1_seq),
      .ack1_valid  (ack1_valid),
      .frames_ok   (frames_ok),
      .frames_drop (frames_drop)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: frame-level view of the stream
   logic [31:0] m_hi [2];
   logic        m_seen [2];
   logic        m_in_frame;
   logic        m_v0;
   logic        m_v1;
   int          m_ok;
   int          m_drop;

   typedef struct {
      logic [7:0]  typ;
      logic [7:0]  app;
      logic [31:0] seq;
      logic        keep_full;
      logic        e_v0;
      logic        e_v1;
      logic [31:0] e_s0;
      logic [31:0] e_s1;
      int          e_ok;
      int          e_drop;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] typ, input logic [7:0] app,
                        input logic [31:0] seq, input logic [KEEP_W-1:0] keep, input logic last);
      rx_tvalid = v;
      rx_tlast  = last;
      rx_tkeep  = keep;
      rx_tdata  = '0;
      rx_tdata[DATA_W-1 -: 32] = $urandom;
      rx_tdata[63:48]          = 16'($urandom);
      rx_tdata[7:0]            = typ;
      rx_tdata[15:8]           = app;
      rx_tdata[47:16]          = seq;
      rx_tuser                 = {$urandom, $urandom};
   endtask

   task automatic model_reset();
      m_hi[0] = 32'h0; m_hi[1] = 32'h0;
      m_seen[0] = 1'b0; m_seen[1] = 1'b0;
      m_in_frame = 1'b0;
      m_v0 = 1'b0; m_v1 = 1'b0;
      m_ok = 0; m_drop = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven
   task automatic model_step();
      logic [7:0]  typ;
      logic [7:0]  app;
      logic [31:0] seq;
      int          a;
      m_v0 = 1'b0;
      m_v1 = 1'b0;
      if (rx_tvalid) begin
         if (!m_in_frame) begin
            typ = rx_tdata[7:0];
            app = rx_tdata[15:8];
            seq = rx_tdata[47:16];
            a   = int'(app[0]);
            if (typ == 8'h06 && app < 8'd2 && rx_tkeep[5:0] == 6'h3F &&
                (!m_seen[a] || $signed(seq - m_hi[a]) > 0)) begin
               m_hi[a]   = seq;
               m_seen[a] = 1'b1;
               if (a == 0) m_v0 = 1'b1;
               else        m_v1 = 1'b1;
               if (m_ok < CNT_MAX) m_ok++;
            end else begin
               if (m_drop < CNT_MAX) m_drop++;
            end
         end
         m_in_frame = !rx_tlast;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".tready"}, {31'b0, rx_tready}, 32'd1);
      chk({tag, ".ack0_valid"}, {31'b0, ack0_valid}, {31'b0, m_v0});
      chk({tag, ".ack1_valid"}, {31'b0, ack1_valid}, {31'b0, m_v1});
      chk({tag, ".ack0_seq"}, ack0_seq, m_hi[0]);
      chk({tag, ".ack1_seq"}, ack1_seq, m_hi[1]);
      chk({tag, ".frames_ok"}, 32'(frames_ok), 32'(m_ok));
      chk({tag, ".frames_drop"}, 32'(frames_drop), 32'(m_drop));
   endtask

   task automatic step_chk(input string tag, input logic v, input logic [7:0] typ, input logic [7:0] app,
                           input logic [31:0] seq, input logic [KEEP_W-1:0] keep, input logic last);
      drive(v, typ, app, seq, keep, last);
      model_step();
      tick();
      check_model(tag);
   endtask

   // Assert reset away from the clock edge; everything must read zero
   task automatic do_reset();
      resetn = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 32'h0, '1, 1'b0);
      model_reset();
      #1;
      chk("rst.tready", {31'b0, rx_tready}, 32'd0);
      chk("rst.ack0_valid", {31'b0, ack0_valid}, 32'd0);
      chk("rst.ack1_valid", {31'b0, ack1_valid}, 32'd0);
      chk("rst.ack0_seq", ack0_seq, 32'd0);
      chk("rst.ack1_seq", ack1_seq, 32'd0);
      chk("rst.frames_ok", 32'(frames_ok), 32'd0);
      chk("rst.frames_drop", 32'(frames_drop), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      tick();
   endtask

   initial begin
      logic [7:0]        r_typ;
      logic [7:0]        r_app;
      logic [31:0]       r_seq;
      logic [KEEP_W-1:0] r_keep;

      tbl[0]  = '{8'h06, 8'h00, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1, 0};
      tbl[1]  = '{8'h06, 8'h00, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 2, 0};
      tbl[2]  = '{8'h06, 8'h00, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 2, 1};
      tbl[3]  = '{8'h06, 8'h01, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 32'h5, 32'h5, 3, 1};
      tbl[4]  = '{8'h06, 8'h01, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 32'h5, 32'h5, 3, 2};
      tbl[5]  = '{8'h06, 8'h01, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 32'h5, 32'h5, 3, 3};
      tbl[6]  = '{8'h07, 8'h00, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h5, 32'h5, 3, 4};
      tbl[7]  = '{8'h06, 8'h02, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h5, 32'h5, 3, 5};
      tbl[8]  = '{8'h06, 8'h00, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h5, 32'h5, 3, 6};
      tbl[9]  = '{8'h06, 8'h00, 32'h0000_0006, 1'b1, 1'b1, 1'b0, 32'h6, 32'h5, 4, 6};
      tbl[10] = '{8'h06, 8'h00, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 32'h7, 32'h5, 5, 6};
      tbl[11] = '{8'h06, 8'h01, 32'h0000_0006, 1'b1, 1'b0, 1'b1, 32'h7, 32'h6, 6, 6};
      tbl[12] = '{8'h06, 8'h00, 32'h8000_0007, 1'b1, 1'b0, 1'b0, 32'h7, 32'h6, 6, 7};
      tbl[13] = '{8'h06, 8'h00, 32'h8000_0006, 1'b1, 1'b1, 1'b0, 32'h8000_0006, 32'h6, 7, 7};

      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      rx_tkeep  = '0;
      rx_tdata  = '0;
      rx_tuser  = '0;
      do_reset();

      // First frame after reset: APP0 seq 1
      drive(1'b1, 8'h06, 8'h00, 32'h1, '1, 1'b1);
      model_step();
      chk("t1.tready", {31'b0, rx_tready}, 32'd1);
      tick();
      chk("t1.ack0_valid", {31'b0, ack0_valid}, 32'd1);
      chk("t1.ack0_seq", ack0_seq, 32'd1);
      chk("t1.frames_ok", 32'(frames_ok), 32'd1);
      drive(1'b0, 8'h06, 8'h00, 32'h1, '1, 1'b1);
      model_step();
      tick();
      chk("t1.pulse_end", {31'b0, ack0_valid}, 32'd0);

      // Table of back-to-back single-beat frames from a clean reset
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, tbl[i].typ, tbl[i].app, tbl[i].seq,
               tbl[i].keep_full ? {KEEP_W{1'b1}} : 64'h1F, 1'b1);
         model_step();
         tick();
         chk($sformatf("tbl%0d.ack0_valid", i), {31'b0, ack0_valid}, {31'b0, tbl[i].e_v0});
         chk($sformatf("tbl%0d.ack1_valid", i), {31'b0, ack1_valid}, {31'b0, tbl[i].e_v1});
         chk($sformatf("tbl%0d.ack0_seq", i), ack0_seq, tbl[i].e_s0);
         chk($sformatf("tbl%0d.ack1_seq", i), ack1_seq, tbl[i].e_s1);
         chk($sformatf("tbl%0d.frames_ok", i), 32'(frames_ok), 32'(tbl[i].e_ok));
         chk($sformatf("tbl%0d.frames_drop", i), 32'(frames_drop), 32'(tbl[i].e_drop));
      end

      // 3-beat frame with a valid gap; tail beats look like fresh APP0 ACKs
      step_chk("mb.hdr",  1'b1, 8'h06, 8'h01, 32'h0000_000F, '1, 1'b0);
      step_chk("mb.gap",  1'b0, 8'h06, 8'h00, 32'h9000_0000, '1, 1'b1);
      step_chk("mb.b2",   1'b1, 8'h06, 8'h00, 32'h9000_0000, '1, 1'b0);
      step_chk("mb.gap2", 1'b0, 8'h06, 8'h00, 32'h9000_0000, '1, 1'b1);
      step_chk("mb.b3",   1'b1, 8'h06, 8'h00, 32'h9000_0001, '1, 1'b1);
      step_chk("mb.next", 1'b1, 8'h06, 8'h00, 32'h0000_0003, '1, 1'b1);
      chk("mb.ack1_seq", ack1_seq, 32'h0000_000F);
      chk("mb.ack0_seq", ack0_seq, 32'h0000_0003);
      chk("mb.frames_ok", 32'(frames_ok), 32'd9);

      // Reset in the middle of a frame; the tail is then parsed as a header
      step_chk("mr.hdr", 1'b1, 8'h06, 8'h01, 32'h0000_0020, '1, 1'b0);
      step_chk("mr.b2",  1'b1, 8'h07, 8'h00, 32'h0000_0000, '1, 1'b0);
      do_reset();
      step_chk("mr.tail", 1'b1, 8'h07, 8'h00, 32'h0000_0000, '1, 1'b1);
      step_chk("mr.new",  1'b1, 8'h06, 8'h00, 32'h0000_0009, '1, 1'b1);
      chk("mr.ack0_seq", ack0_seq, 32'h0000_0009);
      chk("mr.frames_drop", 32'(frames_drop), 32'd1);

      // Random stream against the model, long enough to saturate counters
      for (int n = 0; n < 4000; n++) begin
         r_typ  = ($urandom_range(0, 9) == 0) ? 8'h07 : 8'h06;
         r_app  = ($urandom_range(0, 4) == 0) ? 8'h02 : 8'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 7)
            r_seq = m_hi[r_app[0]] + 32'($urandom_range(0, 3)) - 32'd1;
         else
            r_seq = $urandom;
         r_keep = ($urandom_range(0, 9) == 0) ? 64'h3E : {KEEP_W{1'b1}};
         step_chk("rnd", ($urandom_range(0, 3) != 0), r_typ, r_app, r_seq, r_keep,
                  ($urandom_range(0, 2) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
